// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer for the MIPS-subset datapath: a Moore FSM whose
// only Mealy terms are the FETCH ir_write/pc_write strobes gated by mem_ready.
module mc_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] instr_op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_illegal;

  // State register and sticky trap flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= r_illegal | (w_next == S_TRAP);
    end
  end

  // Next-state and output decode; reset forces every output low combinationally
  always_comb begin
    w_next        = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    state         = 4'd0;

    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (instr_op)
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_R:         w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDI_EX;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        case (instr_op)
          OP_LW:   w_next = S_MEM_RD;
          OP_SW:   w_next = S_MEM_WR;
          default: w_next = S_TRAP;
        endcase
      end
      S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   w_next = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC:     w_next = S_R_WB;
      S_ADDI_EX:  w_next = S_ADDI_WB;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase

    if (rst_n) begin
      state      = r_state;
      illegal_op = r_illegal;
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:   alu_src_b = 2'b11;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        S_ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_ADDI_WB:  reg_write = 1'b1;
        default:    alu_op = 2'b00;
      endcase
    end else begin
      state = 4'd0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench: instruction-level phase lists plus a per-state output
// table, driven with directed scenarios and randomized opcodes/stalls/resets.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] instr_op;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  mc_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .instr_op(instr_op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op;
    logic [3:0] state;
  } outs_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int       q[$];      // remaining phases of the current instruction
  logic [5:0] prog[$]; // queued opcodes for directed scenarios
  logic [5:0] cur_op;

  task automatic check_val(input string tag, input logic [20:0] got, input logic [20:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic void load_phases(input logic [5:0] op);
    case (op)
      6'b000000: q = '{0, 1, 6, 7};
      6'b100011: q = '{0, 1, 2, 3, 4};
      6'b101011: q = '{0, 1, 2, 5};
      6'b000100: q = '{0, 1, 8};
      6'b000010: q = '{0, 1, 9};
      6'b001000: q = '{0, 1, 10, 11};
      default:   q = '{0, 1, 12};
    endcase
  endfunction

  function automatic outs_t spec_outs(input int st, input logic mr);
    outs_t o;
    o = '0;
    o.state = st[3:0];
    case (st)
      0:  begin o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
      1:  o.alu_src_b = 2'b11;
      2:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      3:  begin o.mem_read = 1'b1; o.i_or_d = 1'b1; end
      4:  begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
      5:  begin o.mem_write = 1'b1; o.i_or_d = 1'b1; end
      6:  begin o.alu_src_a = 1'b1; o.alu_op = 2'b10; end
      7:  begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
      8:  begin o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_write_cond = 1'b1; o.pc_source = 2'b01; end
      9:  begin o.pc_write = 1'b1; o.pc_source = 2'b10; end
      10: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      11: o.reg_write = 1'b1;
      12: o.illegal_op = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] legal [6];
    legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    if ($urandom_range(0, 15) == 0) return 6'($urandom_range(0, 63));
    return legal[$urandom_range(0, 5)];
  endfunction

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic cycle(input logic rn, input logic mr);
    outs_t got, exp;
    int    cur;
    @(negedge clk);
    if (q.size() == 0) begin
      cur_op = (prog.size() != 0) ? prog.pop_front() : pick_op();
      load_phases(cur_op);
    end
    cur       = q[0];
    rst_n     = rn;
    mem_ready = mr;
    instr_op  = (cur == 0) ? 6'($urandom_range(0, 63)) : cur_op;
    #2;
    got = '{pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
            pc_source, illegal_op, state};
    exp = rn ? spec_outs(cur, mr) : outs_t'('0);
    check_val(rn ? "outs" : "reset_outs", got, exp);
    if (got.mem_read && got.mem_write) check_val("rd_wr_excl", 21'd1, 21'd0);
    @(posedge clk);
    cyc++;
    if (!rn) q.delete();
    else if (cur == 12) begin end
    else if ((cur == 0 || cur == 3 || cur == 5) && !mr) begin end
    else void'(q.pop_front());
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; instr_op = 6'd0;

    // Reset then R-type
    cycle(1'b0, 1'b1);
    prog.push_back(6'b000000);
    repeat (4) cycle(1'b1, 1'b1);

    // lw with two wait cycles in MEM_RD
    prog.push_back(6'b100011);
    cycle(1'b1, 1'b1); cycle(1'b1, 1'b1); cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0); cycle(1'b1, 1'b0); cycle(1'b1, 1'b1); cycle(1'b1, 1'b1);

    // sw, beq, j back to back
    prog.push_back(6'b101011); prog.push_back(6'b000100); prog.push_back(6'b000010);
    repeat (10) cycle(1'b1, 1'b1);

    // addi then an illegal opcode held in TRAP, then reset
    prog.push_back(6'b001000); prog.push_back(6'b111111);
    repeat (4) cycle(1'b1, 1'b1);
    repeat (23) cycle(1'b1, 1'($urandom_range(0, 1)));
    cycle(1'b0, 1'b1);

    // FETCH stalled three cycles, then an R-type completes
    prog.push_back(6'b000000);
    cycle(1'b1, 1'b0); cycle(1'b1, 1'b0); cycle(1'b1, 1'b0);
    repeat (4) cycle(1'b1, 1'b1);

    // Reset during a MEM_WR wait, then restart
    prog.push_back(6'b101011);
    cycle(1'b1, 1'b1); cycle(1'b1, 1'b1); cycle(1'b1, 1'b1); cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    prog.push_back(6'b000100);
    repeat (3) cycle(1'b1, 1'b1);

    // Randomized opcodes, memory stalls and occasional resets
    repeat (3000) cycle(1'($urandom_range(0, 63) != 0), 1'($urandom_range(0, 3) != 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
